// File: rtl/mem_issue_queue_if.sv
// Handshake and data bundle between the issue queue, its producer (decode /
// rename), the common data bus and the downstream LSU.
interface mem_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             enq_valid_i;
  logic             enq_ready_o;
  logic [31:0]      enq_pc_i;
  logic [31:0]      enq_inst_i;
  logic             enq_rs1_rdy_i;
  logic [TAG_W-1:0] enq_rs1_tag_i;
  logic [31:0]      enq_rs1_value_i;
  logic             enq_rs2_rdy_i;
  logic [TAG_W-1:0] enq_rs2_tag_i;
  logic [31:0]      enq_rs2_value_i;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [31:0]      cdb_value_i;
  logic             issue_stall_i;
  logic             issue_valid_o;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic [31:0]      rs1_value_o;
  logic [31:0]      rs2_value_o;
  logic [CNT_W-1:0] count_o;

  // Environment side: drives requests, broadcasts and stall; observes issue.
  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_inst_i,
           enq_rs1_rdy_i, enq_rs1_tag_i, enq_rs1_value_i,
           enq_rs2_rdy_i, enq_rs2_tag_i, enq_rs2_value_i,
           cdb_valid_i, cdb_tag_i, cdb_value_i, issue_stall_i,
    input  enq_ready_o, issue_valid_o, pc_o, inst_o,
           rs1_value_o, rs2_value_o, count_o
  );

  // Queue side.
  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_inst_i,
           enq_rs1_rdy_i, enq_rs1_tag_i, enq_rs1_value_i,
           enq_rs2_rdy_i, enq_rs2_tag_i, enq_rs2_value_i,
           cdb_valid_i, cdb_tag_i, cdb_value_i, issue_stall_i,
    output enq_ready_o, issue_valid_o, pc_o, inst_o,
           rs1_value_o, rs2_value_o, count_o
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: buffers loads/stores with operand values or
// producer tags, wakes operands from the CDB and issues the head entry into
// a registered LSU-facing output stage. Program-order issue keeps memory
// ordering without any address disambiguation.
module mem_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  mem_issue_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs1_tag_d [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_d [DEPTH];
  logic [31:0]      rs1_val_q [DEPTH];
  logic [31:0]      rs1_val_d [DEPTH];
  logic [31:0]      rs2_val_q [DEPTH];
  logic [31:0]      rs2_val_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered issue stage
  logic        issue_valid_q, issue_valid_d;
  logic [31:0] out_pc_q, out_pc_d, out_inst_q, out_inst_d;
  logic [31:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;

  logic             enq_ready, enq_fire, issue_fire;
  logic             enq_hit1, enq_hit2;
  logic [DEPTH-1:0] wake1, wake2;

  // Ready depends on the registered count only: a full queue refuses an
  // enqueue even if the head leaves in the same cycle.
  assign enq_ready  = (count_q != CNT_W'(DEPTH));
  assign enq_fire   = bus.enq_valid_i & enq_ready & ~bus.flush_i;
  // Readiness is taken from registered state, so a wakeup this cycle can
  // only make the head issuable next cycle.
  assign issue_fire = valid_q[head_q] & rs1_rdy_q[head_q] & rs2_rdy_q[head_q]
                      & ~bus.issue_stall_i & ~bus.flush_i;

  // An operand arriving on the CDB in the enqueue cycle is captured directly.
  assign enq_hit1 = bus.cdb_valid_i & (bus.enq_rs1_tag_i == bus.cdb_tag_i);
  assign enq_hit2 = bus.cdb_valid_i & (bus.enq_rs2_tag_i == bus.cdb_tag_i);

  // Per-entry CDB tag match for operands still waiting on a producer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
      assign wake1[gi] = valid_q[gi] & ~rs1_rdy_q[gi] & bus.cdb_valid_i &
                         (rs1_tag_q[gi] == bus.cdb_tag_i);
      assign wake2[gi] = valid_q[gi] & ~rs2_rdy_q[gi] & bus.cdb_valid_i &
                         (rs2_tag_q[gi] == bus.cdb_tag_i);
    end
  endgenerate

  // Queue next state: wakeup, head dequeue, tail enqueue, flush override.
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    head_d    = head_q;
    tail_d    = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) begin
        rs1_rdy_d[i] = 1'b1;
        rs1_val_d[i] = bus.cdb_value_i;
      end
      if (wake2[i]) begin
        rs2_rdy_d[i] = 1'b1;
        rs2_val_d[i] = bus.cdb_value_i;
      end
    end
    if (issue_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    // The tail slot is always free here (full blocks enqueue), so it never
    // collides with the head being dequeued.
    if (enq_fire) begin
      valid_d[tail_q]   = 1'b1;
      pc_d[tail_q]      = bus.enq_pc_i;
      inst_d[tail_q]    = bus.enq_inst_i;
      rs1_tag_d[tail_q] = bus.enq_rs1_tag_i;
      rs2_tag_d[tail_q] = bus.enq_rs2_tag_i;
      rs1_rdy_d[tail_q] = bus.enq_rs1_rdy_i | enq_hit1;
      rs2_rdy_d[tail_q] = bus.enq_rs2_rdy_i | enq_hit2;
      rs1_val_d[tail_q] = bus.enq_rs1_rdy_i ? bus.enq_rs1_value_i : bus.cdb_value_i;
      rs2_val_d[tail_q] = bus.enq_rs2_rdy_i ? bus.enq_rs2_value_i : bus.cdb_value_i;
      tail_d            = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
    if (bus.flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Issue stage next state: flush clears, stall freezes, otherwise load or bubble.
  always_comb begin
    issue_valid_d = issue_valid_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    if (bus.flush_i) begin
      issue_valid_d = 1'b0;
      out_inst_d    = '0;
    end else if (!bus.issue_stall_i) begin
      if (issue_fire) begin
        issue_valid_d = 1'b1;
        out_pc_d      = pc_q[head_q];
        out_inst_d    = inst_q[head_q];
        out_rs1_d     = rs1_val_q[head_q];
        out_rs2_d     = rs2_val_q[head_q];
      end else begin
        issue_valid_d = 1'b0;
        out_inst_d    = '0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q       <= '0;
      rs1_rdy_q     <= '0;
      rs2_rdy_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]      <= '0;
        inst_q[i]    <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      rs1_rdy_q     <= rs1_rdy_d;
      rs2_rdy_q     <= rs2_rdy_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      rs1_tag_q     <= rs1_tag_d;
      rs2_tag_q     <= rs2_tag_d;
      rs1_val_q     <= rs1_val_d;
      rs2_val_q     <= rs2_val_d;
    end
  end

  assign bus.enq_ready_o   = enq_ready;
  assign bus.issue_valid_o = issue_valid_q;
  assign bus.pc_o          = out_pc_q;
  assign bus.inst_o        = out_inst_q;
  assign bus.rs1_value_o   = out_rs1_q;
  assign bus.rs2_value_o   = out_rs2_q;
  assign bus.count_o       = count_q;
endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: scripted scenarios plus a randomized run, all
// checked against a queue-based reference model of the issue rules.
module tb_mem_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  mem_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  // Reference model: program-ordered list of waiting instructions.
  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    bit               r1;
    bit               r2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v1;
    logic [31:0]      v2;
  } ent_t;
  ent_t        mq[$];
  bit          e_valid;
  logic [31:0] e_pc, e_inst, e_rs1, e_rs2;

  function automatic logic [132:0] obs();
    return {bus.issue_valid_o, bus.inst_o, bus.pc_o, bus.rs1_value_o,
            bus.rs2_value_o, bus.count_o, bus.enq_ready_o};
  endfunction

  function automatic logic [132:0] expv();
    logic [2:0] c;
    logic       r;
    c = 3'(mq.size());
    r = (mq.size() < DEPTH);
    return {e_valid, e_inst, e_pc, e_rs1, e_rs2, c, r};
  endfunction

  function automatic void model_reset();
    mq.delete();
    e_valid = 0; e_pc = '0; e_inst = '0; e_rs1 = '0; e_rs2 = '0;
  endfunction

  // Apply one clock edge worth of queue rules to the model.
  function automatic void model_edge();
    bit   fire, enq;
    ent_t e;
    fire = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && !bus.issue_stall_i && !bus.flush_i;
    enq  = bus.enq_valid_i && (mq.size() < DEPTH) && !bus.flush_i;
    if (bus.flush_i) begin
      mq.delete();
      e_valid = 0;
      e_inst  = '0;
      return;
    end
    if (bus.cdb_valid_i) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag_i) begin mq[i].r1 = 1; mq[i].v1 = bus.cdb_value_i; end
        if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag_i) begin mq[i].r2 = 1; mq[i].v2 = bus.cdb_value_i; end
      end
    end
    if (!bus.issue_stall_i) begin
      if (fire) begin
        e_valid = 1; e_pc = mq[0].pc; e_inst = mq[0].inst; e_rs1 = mq[0].v1; e_rs2 = mq[0].v2;
        void'(mq.pop_front());
        $display("issue pc=%08h inst=%08h rs1=%08h rs2=%08h", e_pc, e_inst, e_rs1, e_rs2);
      end else begin
        e_valid = 0;
        e_inst  = '0;
      end
    end
    if (enq) begin
      e.pc = bus.enq_pc_i; e.inst = bus.enq_inst_i;
      e.t1 = bus.enq_rs1_tag_i; e.t2 = bus.enq_rs2_tag_i;
      e.r1 = bus.enq_rs1_rdy_i; e.v1 = bus.enq_rs1_value_i;
      e.r2 = bus.enq_rs2_rdy_i; e.v2 = bus.enq_rs2_value_i;
      if (!e.r1 && bus.cdb_valid_i && e.t1 == bus.cdb_tag_i) begin e.r1 = 1; e.v1 = bus.cdb_value_i; end
      if (!e.r2 && bus.cdb_valid_i && e.t2 == bus.cdb_tag_i) begin e.r2 = 1; e.v2 = bus.cdb_value_i; end
      mq.push_back(e);
    end
  endfunction

  task automatic idle();
    bus.flush_i = 0; bus.enq_valid_i = 0; bus.enq_pc_i = '0; bus.enq_inst_i = '0;
    bus.enq_rs1_rdy_i = 0; bus.enq_rs1_tag_i = '0; bus.enq_rs1_value_i = '0;
    bus.enq_rs2_rdy_i = 0; bus.enq_rs2_tag_i = '0; bus.enq_rs2_value_i = '0;
    bus.cdb_valid_i = 0; bus.cdb_tag_i = '0; bus.cdb_value_i = '0; bus.issue_stall_i = 0;
  endtask

  task automatic set_enq(input logic [31:0] pc, input logic [31:0] inst,
                         input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                         input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
    bus.enq_valid_i = 1; bus.enq_pc_i = pc; bus.enq_inst_i = inst;
    bus.enq_rs1_rdy_i = r1; bus.enq_rs1_tag_i = t1; bus.enq_rs1_value_i = v1;
    bus.enq_rs2_rdy_i = r2; bus.enq_rs2_tag_i = t2; bus.enq_rs2_value_i = v2;
  endtask

  // One rising edge; the model sees the same inputs; outputs settle by +1.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.issue_valid_o !== 1'b0 || bus.inst_o !== 32'h0) begin errors++; $display("FAIL reset_out: got valid=%b inst=%h want 0/0", bus.issue_valid_o, bus.inst_o); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset_vec: got %h want %h", obs(), expv()); end
    checks++; if (bus.enq_ready_o !== 1'b1 || bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_ready: got ready=%b count=%0d want 1/0", bus.enq_ready_o, bus.count_o); end
  endtask

  task automatic test_basic();
    set_enq(32'h10, 32'h00202223, 1, 0, 32'h0, 1, 0, 32'hFFFF);
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL basic_enq: got %h want %h", obs(), expv()); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early: got valid=%b want 0", bus.issue_valid_o); end
    idle();
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL basic_issue: got %h want %h", obs(), expv()); end
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.inst_o !== 32'h00202223 || bus.rs2_value_o !== 32'hFFFF) begin errors++; $display("FAIL basic_fields: got v=%b inst=%h rs2=%h want 1/00202223/0000ffff", bus.issue_valid_o, bus.inst_o, bus.rs2_value_o); end
    step();
    checks++; if (bus.inst_o !== 32'h0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL basic_bubble: got inst=%h count=%0d want 0/0", bus.inst_o, bus.count_o); end
  endtask

  task automatic test_wakeup();
    set_enq(32'h20, 32'h0000a083, 0, 4'd3, 32'h0, 1, 0, 32'h0);
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL wake_enq1: got %h want %h", obs(), expv()); end
    set_enq(32'h24, 32'h0020a223, 1, 0, 32'h40, 1, 0, 32'h55);
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL wake_enq2: got %h want %h", obs(), expv()); end
    idle();
    step();
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_blocked: got valid=%b pc=%h want 0", bus.issue_valid_o, bus.pc_o); end
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 4'd3; bus.cdb_value_i = 32'h100;
    step();
    checks++; if (bus.issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_nobypass: got valid=%b want 0", bus.issue_valid_o); end
    idle();
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL wake_load: got %h want %h", obs(), expv()); end
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.pc_o !== 32'h20 || bus.rs1_value_o !== 32'h100) begin errors++; $display("FAIL wake_load_fields: got v=%b pc=%h rs1=%h want 1/20/100", bus.issue_valid_o, bus.pc_o, bus.rs1_value_o); end
    step();
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.pc_o !== 32'h24) begin errors++; $display("FAIL wake_store: got v=%b pc=%h want 1/24", bus.issue_valid_o, bus.pc_o); end
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL wake_drain: got %h want %h", obs(), expv()); end
  endtask

  task automatic test_bypass();
    set_enq(32'h30, 32'h0002a303, 0, 4'd5, 32'h0, 1, 0, 32'h7);
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 4'd5; bus.cdb_value_i = 32'hABCD;
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL bypass_enq: got %h want %h", obs(), expv()); end
    idle();
    step();
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.rs1_value_o !== 32'hABCD) begin errors++; $display("FAIL bypass_issue: got v=%b rs1=%h want 1/0000abcd", bus.issue_valid_o, bus.rs1_value_o); end
    step();
  endtask

  task automatic test_full();
    for (int k = 0; k < DEPTH; k++) begin
      set_enq(32'h40 + 32'(4 * k), 32'h100 + 32'(k), 0, 4'(k + 1), 32'h0, 1, 0, 32'(k));
      step();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL full_fill%0d: got %h want %h", k, obs(), expv()); end
    end
    checks++; if (bus.enq_ready_o !== 1'b0 || bus.count_o !== 3'd4) begin errors++; $display("FAIL full_state: got ready=%b count=%0d want 0/4", bus.enq_ready_o, bus.count_o); end
    set_enq(32'h50, 32'hDEAD, 1, 0, 32'h1, 1, 0, 32'h2);
    step();
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_reject: got count=%0d want 4", bus.count_o); end
    idle();
    for (int k = 0; k <= DEPTH; k++) begin
      bus.cdb_valid_i = (k < DEPTH); bus.cdb_tag_i = 4'(k + 1); bus.cdb_value_i = 32'h1000 + 32'(k);
      step();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL full_wake%0d: got %h want %h", k, obs(), expv()); end
      if (k >= 1) begin
        checks++; if (bus.issue_valid_o !== 1'b1 || bus.pc_o !== 32'h40 + 32'(4 * (k - 1))) begin errors++; $display("FAIL full_order%0d: got v=%b pc=%h want 1/%h", k, bus.issue_valid_o, bus.pc_o, 32'h40 + 32'(4 * (k - 1))); end
      end
    end
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      set_enq(32'h60 + 32'(4 * k), 32'h200 + 32'(k), 1, 0, 32'(k), 1, 0, 32'(k + 9));
      step();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL full_wrap%0d: got %h want %h", k, obs(), expv()); end
    end
    idle();
    repeat (2) begin
      step();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL full_drain: got %h want %h", obs(), expv()); end
    end
    checks++; if (bus.count_o !== 3'd0 || bus.pc_o !== 32'h6C) begin errors++; $display("FAIL full_last: got count=%0d pc=%h want 0/6c", bus.count_o, bus.pc_o); end
  endtask

  task automatic test_stall();
    set_enq(32'h80, 32'h00112023, 1, 0, 32'hA1, 1, 0, 32'hB1);
    step();
    set_enq(32'h84, 32'h00212223, 1, 0, 32'hA2, 1, 0, 32'hB2);
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL stall_first: got %h want %h", obs(), expv()); end
    idle();
    bus.issue_stall_i = 1;
    repeat (3) begin
      step();
      checks++; if (bus.issue_valid_o !== 1'b1 || bus.pc_o !== 32'h80 || bus.count_o !== 3'd1) begin errors++; $display("FAIL stall_hold: got v=%b pc=%h count=%0d want 1/80/1", bus.issue_valid_o, bus.pc_o, bus.count_o); end
    end
    bus.issue_stall_i = 0;
    step();
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.pc_o !== 32'h84 || bus.rs2_value_o !== 32'hB2) begin errors++; $display("FAIL stall_resume: got v=%b pc=%h rs2=%h want 1/84/b2", bus.issue_valid_o, bus.pc_o, bus.rs2_value_o); end
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL stall_drain: got %h want %h", obs(), expv()); end
  endtask

  task automatic test_flush();
    bus.issue_stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      set_enq(32'h90 + 32'(4 * k), 32'h300 + 32'(k), 1, 0, 32'h1, 1, 0, 32'h2);
      step();
    end
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL flush_pre: got count=%0d want 3", bus.count_o); end
    bus.issue_stall_i = 0;
    set_enq(32'h9C, 32'h303, 1, 0, 32'h1, 1, 0, 32'h2);
    bus.flush_i = 1;
    step();
    checks++; if (bus.count_o !== 3'd0 || bus.issue_valid_o !== 1'b0 || bus.inst_o !== 32'h0) begin errors++; $display("FAIL flush_clear: got count=%0d v=%b inst=%h want 0/0/0", bus.count_o, bus.issue_valid_o, bus.inst_o); end
    idle();
    repeat (3) begin
      step();
      checks++; if (bus.issue_valid_o !== 1'b0 || obs() !== expv()) begin errors++; $display("FAIL flush_ghost: got %h want %h", obs(), expv()); end
    end
  endtask

  task automatic test_async_reset();
    set_enq(32'hA0, 32'h00b02023, 1, 0, 32'h11, 1, 0, 32'h22);
    step();
    set_enq(32'hA4, 32'h00b02223, 0, 4'd9, 32'h0, 1, 0, 32'h33);
    step();
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.count_o !== 3'd1) begin errors++; $display("FAIL areset_pre: got v=%b count=%0d want 1/1", bus.issue_valid_o, bus.count_o); end
    idle();
    #2;
    rst = 1;
    #1;
    model_reset();
    checks++; if (obs() !== expv() || bus.pc_o !== 32'h0) begin errors++; $display("FAIL areset_now: got %h want %h", obs(), expv()); end
    @(negedge clk);
    rst = 0;
    bus.cdb_valid_i = 1; bus.cdb_tag_i = 4'd9; bus.cdb_value_i = 32'h44;
    step();
    idle();
    step();
    checks++; if (obs() !== expv()) begin errors++; $display("FAIL areset_after: got %h want %h", obs(), expv()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.enq_valid_i     = ($urandom_range(0, 99) < 60);
      bus.enq_pc_i        = $urandom;
      bus.enq_inst_i      = $urandom;
      bus.enq_rs1_rdy_i   = $urandom_range(0, 1);
      bus.enq_rs1_tag_i   = TAG_W'($urandom);
      bus.enq_rs1_value_i = $urandom;
      bus.enq_rs2_rdy_i   = $urandom_range(0, 1);
      bus.enq_rs2_tag_i   = TAG_W'($urandom);
      bus.enq_rs2_value_i = $urandom;
      bus.cdb_valid_i     = $urandom_range(0, 1);
      bus.cdb_tag_i       = TAG_W'($urandom);
      bus.cdb_value_i     = $urandom;
      bus.issue_stall_i   = ($urandom_range(0, 99) < 20);
      bus.flush_i         = ($urandom_range(0, 99) < 3);
      step();
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL random%0d: got %h want %h", n, obs(), expv()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
